// File: rtl/l2_request_arbiter_pkg.sv
// Shared defaults and helpers for the L2 request arbiter and its round-robin core.
// Parameter defaults are overridden at instantiation from the gpgpu top-level defines.
package l2_request_arbiter_pkg;

    localparam int unsigned L2A_DEF_NUM_REQUESTERS  = 32'd4;
    localparam int unsigned L2A_DEF_PACKET_WIDTH    = 32'd64;
    localparam int unsigned L2A_DEF_MAX_OUTSTANDING = 32'd4;

    // Index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic int unsigned onehot_to_index(input logic [31:0] onehot);
        int unsigned idx;
        idx = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: the entry after the last winner has top priority.
// The pointer only moves when the caller signals that the grant was consumed.
module rr_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = L2A_DEF_NUM_REQUESTERS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant_oh
);

    localparam int unsigned IDX_W = (NUM_ENTRIES > 32'd1) ? $clog2(NUM_ENTRIES) : 32'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 32'd1);

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;

    // Scan from last_grant+1 with wrap; first requesting entry wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant_oh = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned off = 1; off <= NUM_ENTRIES; off++) begin
            cand = IDX_W'((32'(last_grant_q) + off) % NUM_ENTRIES);
            if (!found && request[cand]) begin
                grant_oh[cand] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Pointer next state: follow the winner only on a consumed grant.
    always_comb begin
        if (update_lru) begin
            last_grant_d = IDX_W'(onehot_to_index(32'(grant_oh)));
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Pointer register; reset makes entry 0 the first to be served.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= LAST_IDX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the single L2 request port among all cores: round-robin selection,
// per-requester outstanding-request credit, and one registered output stage.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS  = L2A_DEF_NUM_REQUESTERS,
    parameter int unsigned PACKET_WIDTH    = L2A_DEF_PACKET_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = L2A_DEF_MAX_OUTSTANDING,
    localparam int unsigned RID_W = (NUM_REQUESTERS > 32'd1) ? $clog2(NUM_REQUESTERS) : 32'd1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS*PACKET_WIDTH-1:0] req_packet,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic                                 out_valid,
    output logic [PACKET_WIDTH-1:0]              out_packet,
    output logic [RID_W-1:0]                     out_requester,
    input  logic                                 out_ready,
    input  logic                                 rsp_valid,
    input  logic [RID_W-1:0]                     rsp_requester,
    output logic [NUM_REQUESTERS-1:0]            credit_stall
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 32'd1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REQUESTERS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_REQUESTERS-1:0][CNT_W-1:0] cnt_d;
    logic                                 out_valid_q;
    logic                                 out_valid_d;
    logic [PACKET_WIDTH-1:0]              out_packet_q;
    logic [PACKET_WIDTH-1:0]              out_packet_d;
    logic [RID_W-1:0]                     out_requester_q;
    logic [RID_W-1:0]                     out_requester_d;

    logic                                 load_en_s;
    logic                                 accept_s;
    logic [NUM_REQUESTERS-1:0]            eligible_s;
    logic [NUM_REQUESTERS-1:0]            grant_s;
    logic [NUM_REQUESTERS-1:0]            rsp_hit_s;
    logic [NUM_REQUESTERS-1:0]            cnt_zero_s;
    logic [RID_W-1:0]                     grant_idx_s;
    logic [PACKET_WIDTH-1:0]              pkt_arr_s [NUM_REQUESTERS];

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_unpack
        assign pkt_arr_s[g] = req_packet[g*PACKET_WIDTH +: PACKET_WIDTH];
    end

    rr_arbiter #(
        .NUM_ENTRIES (NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .request    (eligible_s),
        .update_lru (accept_s),
        .grant_oh   (grant_s)
    );

    // Eligibility, credit status and response decode per requester.
    always_comb begin
        eligible_s   = '0;
        credit_stall = '0;
        rsp_hit_s    = '0;
        cnt_zero_s   = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            credit_stall[i] = (cnt_q[i] == MAX_CNT);
            eligible_s[i]   = req_valid[i] && (cnt_q[i] != MAX_CNT);
            rsp_hit_s[i]    = rsp_valid && (rsp_requester == RID_W'(i));
            cnt_zero_s[i]   = (cnt_q[i] == {CNT_W{1'b0}});
        end
    end

    // Handshake: accept only when the output register is free or draining.
    always_comb begin
        load_en_s = !out_valid_q || out_ready;
        if (load_en_s && !reset) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        accept_s    = |req_ready;
        grant_idx_s = RID_W'(onehot_to_index(32'(grant_s)));
    end

    // Outstanding counters; a response arriving with zero outstanding is dropped.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            if (req_ready[i] && rsp_hit_s[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (req_ready[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rsp_hit_s[i] && !cnt_zero_s[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Output stage next state: load on accept, clear valid on a bare drain, else hold.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_packet_d    = out_packet_q;
        out_requester_d = out_requester_q;
        if (accept_s) begin
            out_valid_d     = 1'b1;
            out_packet_d    = pkt_arr_s[grant_idx_s];
            out_requester_d = grant_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            out_packet_q    <= '0;
            out_requester_q <= '0;
        end else begin
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            out_packet_q    <= out_packet_d;
            out_requester_q <= out_requester_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_packet    = out_packet_q;
    assign out_requester = out_requester_q;

    // A response for a requester with nothing outstanding indicates an L2 protocol slip.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(|(rsp_hit_s & cnt_zero_s)))
            else $warning("l2_request_arbiter: response for requester %0d with no outstanding request",
                          rsp_requester);
        end else begin
        end
    end

    if ((32'd1 << RID_W) > NUM_REQUESTERS) begin : g_rid_range_chk
        // Out-of-range requester ids decode to no counter; report them.
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!(rsp_valid && (32'(rsp_requester) >= NUM_REQUESTERS)))
                else $error("l2_request_arbiter: response requester id %0d out of range", rsp_requester);
            end else begin
            end
        end
    end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized and directed bench for l2_request_arbiter against a transaction-level model.
module tb_l2_request_arbiter;

    localparam int NR   = 4;
    localparam int PW   = 64;
    localparam int MAXO = 4;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*PW-1:0]  req_packet;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [PW-1:0]     out_packet;
    logic [1:0]        out_requester;
    logic              out_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_requester;
    logic [NR-1:0]     credit_stall;

    l2_request_arbiter #(
        .NUM_REQUESTERS  (NR),
        .PACKET_WIDTH    (PW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_packet    (req_packet),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_packet    (out_packet),
        .out_requester (out_requester),
        .out_ready     (out_ready),
        .rsp_valid     (rsp_valid),
        .rsp_requester (rsp_requester),
        .credit_stall  (credit_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what has been accepted and what is outstanding.
    int          m_cnt [NR];
    logic        m_ov;
    logic [63:0] m_pkt;
    int          m_or;
    int          m_last;
    logic [63:0] pk [NR];
    int          last_acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_ov   = 1'b0;
        m_pkt  = 64'd0;
        m_or   = 0;
        m_last = NR - 1;
    endtask

    // One clock: drive inputs, check outputs and grant against the model, advance the model.
    task automatic cycle(input logic [3:0] v, input logic ordy, input logic rv,
                         input logic [1:0] rr, input logic rst);
        int g;
        int idx;
        logic [3:0] exp_rdy;
        logic [3:0] exp_stall;
        @(negedge clk);
        reset         = rst;
        req_valid     = v;
        out_ready     = ordy;
        rsp_valid     = rv;
        rsp_requester = rr;
        for (int i = 0; i < NR; i++) begin
            pk[i] = {$urandom(), $urandom()};
            req_packet[i*PW +: PW] = pk[i];
        end
        #1;
        exp_stall = 4'b0000;
        for (int i = 0; i < NR; i++) exp_stall[i] = (m_cnt[i] == MAXO);
        check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check_eq("out_packet", out_packet, m_pkt);
        check_eq("out_requester", {62'd0, out_requester}, 64'(m_or));
        check_eq("credit_stall", {60'd0, credit_stall}, {60'd0, exp_stall});
        g = -1;
        if (!rst && (!m_ov || ordy)) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (g < 0 && v[idx] && m_cnt[idx] != MAXO) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check_eq("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        last_acc = g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (g == i && rv && rr == 2'(i)) begin
                end else if (g == i) begin
                    m_cnt[i]++;
                end else if (rv && rr == 2'(i) && m_cnt[i] > 0) begin
                    m_cnt[i]--;
                end
            end
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_pkt  = pk[g];
                m_or   = g;
                m_last = g;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    initial begin
        logic [63:0] held_pkt;
        logic [1:0]  held_rid;
        int          r;
        reset = 1'b1; req_valid = '0; req_packet = '0; out_ready = 1'b0;
        rsp_valid = 1'b0; rsp_requester = 2'd0; last_acc = -1;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and full-rate round robin with responses to the drained packet.
        cycle(4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            cycle(4'b1111, 1'b1, m_ov, 2'(m_or), 1'b0);
            check_eq("t1_grant", 64'(last_acc), 64'(k % NR));
            #1;
            check_eq("t1_out_valid", {63'd0, out_valid}, 64'd1);
        end

        // Single requester runs into its credit cap, then one response frees one slot.
        cycle(4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
            check_eq("t2_accept", 64'(last_acc), 64'd2);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
            check_eq("t2_capped", 64'(last_acc), -64'sd1);
            #1;
            check_eq("t2_stall", {60'd0, credit_stall}, 64'h4);
        end
        cycle(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        check_eq("t2_rsp_cycle", 64'(last_acc), -64'sd1);
        cycle(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
        check_eq("t2_reaccept", 64'(last_acc), 64'd2);
        cycle(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
        check_eq("t2_recapped", 64'(last_acc), -64'sd1);

        // Backpressure: output holds, no accepts, release resumes after last winner.
        cycle(4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        #1;
        held_pkt = out_packet;
        held_rid = out_requester;
        check_eq("t3_held_rid", {62'd0, held_rid}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
            check_eq("t3_no_accept", 64'(last_acc), -64'sd1);
            #1;
            check_eq("t3_pkt_stable", out_packet, held_pkt);
            check_eq("t3_rid_stable", {62'd0, out_requester}, {62'd0, held_rid});
        end
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        check_eq("t3_release_grant", 64'(last_acc), 64'd2);

        // Same-cycle accept and response at outstanding=3 leaves the counter at 3.
        cycle(4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        check_eq("t4_accept", 64'(last_acc), 64'd1);
        #1;
        check_eq("t4_no_stall", {60'd0, credit_stall}, 64'd0);
        cycle(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
        #1;
        check_eq("t4_stall_after", {60'd0, credit_stall}, 64'h2);

        // Reset in the middle of traffic.
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
        #1;
        check_eq("t5_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t5_stall", {60'd0, credit_stall}, 64'd0);
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        check_eq("t5_first_grant", 64'(last_acc), 64'd0);

        // Response to an idle requester must not disturb counters or arbitration.
        cycle(4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        check_eq("t6_grant", 64'(last_acc), 64'd0);
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0);
            check_eq("t6_req3", 64'(last_acc), (k < 4) ? 64'd3 : -64'sd1);
        end

        // Randomized traffic with legal responses and occasional resets.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(NR - 1, 0));
            cycle(4'($urandom_range(15, 0)),
                  ($urandom_range(3, 0) != 0),
                  (m_cnt[r] > 0) && ($urandom_range(1, 0) == 1),
                  2'(r),
                  ($urandom_range(63, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
